// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and dimension check for the matrix datapath.
package matrix_pkg;

  localparam int unsigned DIM_MAX = 5;
  localparam int unsigned ELEM_W  = 8;
  localparam int unsigned SLOT_W  = DIM_MAX * DIM_MAX * ELEM_W;
  localparam int unsigned BUS_W   = 2 * SLOT_W;
  localparam int unsigned DIM_W   = 3;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  // Legal when both dimensions are within 1..DIM_MAX.
  function automatic logic dim_ok(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n);
    return (m != '0) && (m <= DIM_W'(DIM_MAX)) && (n != '0) && (n <= DIM_W'(DIM_MAX));
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Packs a row-major element stream into one slot of the two-slot matrix bus.
module matrix_loader
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                slot_sel,
  input  logic [DIM_W-1:0]    m_cfg,
  input  logic [DIM_W-1:0]    n_cfg,
  input  logic                abort,
  input  logic                elem_valid,
  input  logic [ELEM_W-1:0]   elem_data,
  output logic                elem_ready,
  output logic [DIM_W-1:0]    m_a_out,
  output logic [DIM_W-1:0]    n_a_out,
  output logic [DIM_W-1:0]    m_b_out,
  output logic [DIM_W-1:0]    n_b_out,
  output logic [BUS_W-1:0]    matrices_out,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int unsigned IDX_W = $clog2(BUS_W);

  state_t             state;
  logic               slot_q;
  logic [DIM_W-1:0]   m_q;
  logic [DIM_W-1:0]   n_q;
  logic [DIM_W-1:0]   row;
  logic [DIM_W-1:0]   col;
  logic               hs;
  logic               last_col;
  logic               last_elem;
  logic [IDX_W-1:0]   elem_base;

  // Abort wins over the handshake so the offered element is never taken.
  assign elem_ready = (state == LOAD) && !abort;
  assign hs         = elem_valid && elem_ready;
  assign last_col   = (col == n_q - DIM_W'(1));
  assign last_elem  = hs && last_col && (row == m_q - DIM_W'(1));
  assign elem_base  = (slot_q ? IDX_W'(SLOT_W) : '0)
                    + (IDX_W'(row) * IDX_W'(DIM_MAX) + IDX_W'(col)) * IDX_W'(ELEM_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      slot_q       <= 1'b0;
      m_q          <= '0;
      n_q          <= '0;
      row          <= '0;
      col          <= '0;
      m_a_out      <= '0;
      n_a_out      <= '0;
      m_b_out      <= '0;
      n_b_out      <= '0;
      matrices_out <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (dim_ok(m_cfg, n_cfg)) begin
              slot_q <= slot_sel;
              m_q    <= m_cfg;
              n_q    <= n_cfg;
              row    <= '0;
              col    <= '0;
              busy   <= 1'b1;
              state  <= LOAD;
              // Target slot is cleared and marked invalid until the last element lands.
              if (slot_sel) begin
                matrices_out[BUS_W-1:SLOT_W] <= '0;
                m_b_out <= '0;
                n_b_out <= '0;
              end else begin
                matrices_out[SLOT_W-1:0] <= '0;
                m_a_out <= '0;
                n_a_out <= '0;
              end
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (hs) begin
            matrices_out[elem_base +: ELEM_W] <= elem_data;
            if (last_col) begin
              col <= '0;
              row <= row + DIM_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
            if (last_elem) begin
              done  <= 1'b1;
              state <= DONE;
              if (slot_q) begin
                m_b_out <= m_q;
                n_b_out <= n_q;
              end else begin
                m_a_out <= m_q;
                n_a_out <= n_q;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
